// File: rtl/ksa_swap_if.sv
`default_nettype none
// ============================================================================
// Module   : ksa_swap_if
// Brief    : Start/key/S-RAM bundle between the KSA swap engine and its peers
// Revision : 1.0
// ============================================================================
interface ksa_swap_if #(
    parameter int KEY_LEN = 3
);
    logic                   start;
    logic [8*KEY_LEN-1:0]   secret_key;
    logic [7:0]             address;
    logic [7:0]             data;
    logic                   wren;
    logic [7:0]             q;
    logic                   busy;
    logic                   done;

    // master: upstream control plus the S-RAM read port feeding q
    modport master (
        output start, secret_key, q,
        input  address, data, wren, busy, done
    );

    modport slave (
        input  start, secret_key, q,
        output address, data, wren, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/ksa_swap.sv
`default_nettype none
// ============================================================================
// Module   : ksa_swap
// Brief    : RC4 key-scheduling swap over a 256-byte S-RAM with 1-cycle reads
// Revision : 1.0
// ============================================================================
module ksa_swap #(
    parameter int KEY_LEN = 3
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    ksa_swap_if.slave   bus
);
    localparam int KIDX_W = (KEY_LEN > 1) ? $clog2(KEY_LEN) : 1;
    localparam logic [KIDX_W-1:0] KIDX_LAST = KIDX_W'(KEY_LEN - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_SI   = 3'd1,
        WAIT_SI = 3'd2,
        RD_SJ   = 3'd3,
        WAIT_SJ = 3'd4,
        WR_SI   = 3'd5,
        WR_SJ   = 3'd6,
        DONE    = 3'd7
    } state_t;

    state_t             state_q, state_d;
    logic [7:0]         i_q, i_d;
    logic [7:0]         j_q, j_d;
    logic [KIDX_W-1:0]  kidx_q, kidx_d;
    logic [7:0]         si_q, si_d;
    logic [7:0]         sj_q, sj_d;

    logic [7:0]         w_address;
    logic [7:0]         w_data;
    logic               w_wren;
    logic               w_busy;
    logic               w_done;
    logic [7:0]         w_key_byte [KEY_LEN];

    // Byte 0 is the most significant byte of the key vector
    for (genvar k = 0; k < KEY_LEN; k++) begin : g_key
        assign w_key_byte[k] = bus.secret_key[8*(KEY_LEN-k)-1 -: 8];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            i_q     <= 8'h00;
            j_q     <= 8'h00;
            kidx_q  <= '0;
            si_q    <= 8'h00;
            sj_q    <= 8'h00;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            kidx_q  <= kidx_d;
            si_q    <= si_d;
            sj_q    <= sj_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        i_d       = i_q;
        j_d       = j_q;
        kidx_d    = kidx_q;
        si_d      = si_q;
        sj_d      = sj_q;
        w_address = 8'h00;
        w_data    = 8'h00;
        w_wren    = 1'b0;
        w_busy    = 1'b1;
        w_done    = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                w_busy = 1'b0;
                w_done = (state_q == DONE);
                if (bus.start) begin
                    state_d = RD_SI;
                    i_d     = 8'h00;
                    j_d     = 8'h00;
                    kidx_d  = '0;
                end
            end
            RD_SI: begin
                w_address = i_q;
                state_d   = WAIT_SI;
            end
            WAIT_SI: begin
                si_d    = bus.q;
                j_d     = j_q + bus.q + w_key_byte[kidx_q];
                state_d = RD_SJ;
            end
            RD_SJ: begin
                w_address = j_q;
                state_d   = WAIT_SJ;
            end
            WAIT_SJ: begin
                sj_d    = bus.q;
                state_d = WR_SI;
            end
            WR_SI: begin
                w_address = i_q;
                w_data    = sj_q;
                w_wren    = 1'b1;
                state_d   = WR_SJ;
            end
            WR_SJ: begin
                // When i==j this rewrites the original value, so no special case
                w_address = j_q;
                w_data    = si_q;
                w_wren    = 1'b1;
                if (i_q == 8'hFF) begin
                    state_d = DONE;
                end else begin
                    i_d     = i_q + 8'h01;
                    kidx_d  = (kidx_q == KIDX_LAST) ? '0 : kidx_q + 1'b1;
                    state_d = RD_SI;
                end
            end
            default: begin
                w_busy  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    assign bus.address = w_address;
    assign bus.data    = w_data;
    assign bus.wren    = w_wren;
    assign bus.busy    = w_busy;
    assign bus.done    = w_done;

endmodule
`default_nettype wire

// File: tb/tb_ksa_swap.sv
`default_nettype none
// ============================================================================
// Module   : tb_ksa_swap
// Brief    : Directed self-checking bench for ksa_swap with an S-RAM model
// Revision : 1.0
// ============================================================================
module tb_ksa_swap;
    localparam int KEY_LEN = 3;

    logic clk;
    logic rst_n;
    logic ram_init;

    ksa_swap_if #(.KEY_LEN(KEY_LEN)) bus ();

    ksa_swap #(.KEY_LEN(KEY_LEN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] ram  [256];
    logic [7:0] gold [256];
    logic [7:0] res1 [256];

    // 1-cycle synchronous-read S-RAM; ram_init reloads the identity table
    always @(posedge clk) begin
        if (ram_init) begin
            for (int n = 0; n < 256; n++) ram[n] <= 8'(n);
        end else if (bus.wren) begin
            ram[bus.address] <= bus.data;
        end
        bus.q <= ram[bus.address];
    end

    int n_checks;
    int n_fail;

    int         done_cyc;
    int         wr_cnt;
    int         busy_err;
    logic       done_at_1;
    logic [7:0] wr_addr [4];
    logic [7:0] wr_data [4];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic gold_identity();
        for (int n = 0; n < 256; n++) gold[n] = 8'(n);
    endtask

    task automatic ksa_model(input logic [8*KEY_LEN-1:0] key);
        logic [7:0] j, t, kb;
        j = 8'h00;
        for (int i = 0; i < 256; i++) begin
            kb = 8'(key >> (8 * (KEY_LEN - 1 - (i % KEY_LEN))));
            j  = j + gold[i] + kb;
            t  = gold[i];
            gold[i] = gold[j];
            gold[j] = t;
        end
    endtask

    task automatic compare_ram(input string name);
        int bad;
        bad = -1;
        for (int n = 255; n >= 0; n--) if (ram[n] !== gold[n]) bad = n;
        n_checks++;
        if (bad >= 0) begin
            n_fail++;
            $display("FAIL %s: RAM[%0d] actual=%0h required=%0h", name, bad, ram[bad], gold[bad]);
        end
    endtask

    task automatic load_identity();
        ram_init = 1'b1;
        @(posedge clk); #1;
        ram_init = 1'b0;
    endtask

    // Pulses start (cycle 0) and follows the run; k is the cycle number
    task automatic run_ksa(input logic [8*KEY_LEN-1:0] key, input int extra1,
                           input int extra2, input int abort_at);
        int k;
        bus.secret_key = key;
        wr_cnt = 0; busy_err = 0; done_cyc = -1;
        for (int n = 0; n < 4; n++) begin wr_addr[n] = 8'hxx; wr_data[n] = 8'hxx; end
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        done_at_1 = bus.done;
        k = 1;
        while (!bus.done && k < 3000 && k != abort_at) begin
            if (bus.wren) begin
                if (wr_cnt < 4) begin
                    wr_addr[wr_cnt] = bus.address;
                    wr_data[wr_cnt] = bus.data;
                end
                wr_cnt++;
            end
            if (!bus.busy) busy_err++;
            bus.start = (k == extra1 || k == extra2);
            @(posedge clk); #1;
            bus.start = 1'b0;
            k++;
        end
        if (bus.done) done_cyc = k;
    endtask

    task automatic check_idle_outputs(input string name);
        chk({name, "_address"}, bus.address, 0);
        chk({name, "_data"},    bus.data,    0);
        chk({name, "_wren"},    bus.wren,    0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.secret_key = '0;
        ram_init = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        chk("reset_busy", bus.busy, 0);
        chk("reset_done", bus.done, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_reset_idle_busy", bus.busy, 0);
        chk("post_reset_idle_done", bus.done, 0);
    endtask

    task automatic test_golden();
        load_identity();
        gold_identity();
        ksa_model(24'h000249);
        run_ksa(24'h000249, -1, -1, 0);
        chk("golden_done_cycle", done_cyc, 1537);
        chk("golden_wren_cycles", wr_cnt, 512);
        chk("golden_busy_gaps", busy_err, 0);
        chk("golden_wr0_addr", wr_addr[0], 0);
        chk("golden_wr1_data", wr_data[1], 0);
        chk("golden_wr2_addr", wr_addr[2], 1);
        chk("golden_wr2_data", wr_data[2], 3);
        chk("golden_wr3_addr", wr_addr[3], 3);
        chk("golden_wr3_data", wr_data[3], 1);
        @(negedge clk);
        compare_ram("golden_ram");
        for (int n = 0; n < 256; n++) res1[n] = ram[n];
        check_idle_outputs("done");
        chk("done_busy", bus.busy, 0);
        chk("done_hold", bus.done, 1);
        @(posedge clk); #1;
    endtask

    task automatic test_zero_key();
        load_identity();
        gold_identity();
        ksa_model(24'h000000);
        run_ksa(24'h000000, -1, -1, 0);
        chk("zero_wr0_addr", wr_addr[0], 0);
        chk("zero_wr0_data", wr_data[0], 0);
        chk("zero_wr1_addr", wr_addr[1], 0);
        chk("zero_wr1_data", wr_data[1], 0);
        chk("zero_wr2_addr", wr_addr[2], 1);
        chk("zero_wr3_data", wr_data[3], 1);
        chk("zero_done_cycle", done_cyc, 1537);
        @(negedge clk);
        compare_ram("zero_ram");
        @(posedge clk); #1;
    endtask

    task automatic test_start_ignored();
        load_identity();
        for (int n = 0; n < 256; n++) gold[n] = res1[n];
        run_ksa(24'h000249, 10, 900, 0);
        chk("ignored_done_cycle", done_cyc, 1537);
        chk("ignored_wren_cycles", wr_cnt, 512);
        @(negedge clk);
        compare_ram("ignored_ram");
        @(posedge clk); #1;
    endtask

    task automatic test_reset_midrun();
        int wr_after;
        load_identity();
        run_ksa(24'h000249, -1, -1, 700);
        #2 rst_n = 1'b0;
        #1;
        check_idle_outputs("async_reset");
        chk("async_reset_busy", bus.busy, 0);
        chk("async_reset_done", bus.done, 0);
        wr_after = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (bus.wren) wr_after++;
        end
        chk("reset_no_wren", wr_after, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        load_identity();
        gold_identity();
        ksa_model(24'h000249);
        run_ksa(24'h000249, -1, -1, 0);
        chk("rerun_done_cycle", done_cyc, 1537);
        chk("rerun_wren_cycles", wr_cnt, 512);
        @(negedge clk);
        compare_ram("rerun_ram");
        @(posedge clk); #1;
    endtask

    task automatic test_restart_from_done();
        chk("pre_restart_done", bus.done, 1);
        for (int n = 0; n < 256; n++) gold[n] = ram[n];
        ksa_model(24'h1A2B3C);
        run_ksa(24'h1A2B3C, -1, -1, 0);
        chk("restart_done_falls", done_at_1, 0);
        chk("restart_done_cycle", done_cyc, 1537);
        chk("restart_wren_cycles", wr_cnt, 512);
        @(negedge clk);
        compare_ram("restart_ram");
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_golden();
        test_zero_key();
        test_start_ignored();
        test_reset_midrun();
        test_restart_from_done();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
